// File: rtl/echo_range_filter.sv
// Converts ultrasonic echo widths to rounded cm with a bit-serial restoring divider,
// rejects out-of-range samples, keeps a sliding-window average and flags lost echoes.
module echo_range_filter #(
  parameter int CYC_W      = 17,
  parameter int CYC_PER_CM = 2900,
  parameter int CM_W       = 8,
  parameter int MAX_CM     = 40,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [CYC_W-1:0] cycles_i,
  input  logic             flush_i,
  output logic             cm_valid_o,
  output logic [CM_W-1:0]  cm_o,
  output logic             avg_valid_o,
  output logic [CM_W-1:0]  avg_o,
  output logic             range_err_o,
  output logic             miss_o,
  output logic             busy_o
);

  localparam int DW = CYC_W + 1;
  localparam int RW = CYC_W + 2;
  localparam int SW = CM_W + AVG_LOG2;
  localparam int N  = 2 ** AVG_LOG2;
  localparam int IW = $clog2(DW);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [DW-1:0]       HALF     = DW'(CYC_PER_CM / 2);
  localparam logic [RW-1:0]       DIVISOR  = RW'(CYC_PER_CM);
  localparam logic [DW-1:0]       MAX_Q    = DW'(MAX_CM);
  localparam logic [IW-1:0]       LAST_IT  = IW'(DW - 1);
  localparam logic [AVG_LOG2:0]   N_CNT    = (AVG_LOG2 + 1)'(N);

  logic [1:0]          state;
  logic [IW-1:0]       iter;
  logic [RW-1:0]       rem;
  logic [DW-1:0]       quo;
  logic                res_go;
  logic [DW-1:0]       res_q;
  logic                pending;

  logic [CM_W-1:0]     win [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   win_cnt;
  logic [SW-1:0]       sum;

  logic [RW-1:0]       rem_sh;
  logic                rem_ge;
  logic                accept;
  logic [SW-1:0]       sum_new;
  logic [AVG_LOG2:0]   cnt_new;

  // quo doubles as the dividend shift-out and the quotient shift-in register
  always_comb begin
    rem_sh  = {rem[RW-2:0], quo[DW-1]};
    rem_ge  = (rem_sh >= DIVISOR);
    accept  = (res_q <= MAX_Q);
    sum_new = sum + SW'(res_q[CM_W-1:0]) - SW'(win[wr_ptr]);
    cnt_new = (win_cnt == N_CNT) ? N_CNT : win_cnt + 1'b1;
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      iter    <= '0;
      rem     <= '0;
      quo     <= '0;
      res_go  <= 1'b0;
      res_q   <= '0;
      pending <= 1'b0;
      miss_o  <= 1'b0;
    end else begin
      res_go  <= 1'b0;
      miss_o  <= (start_i && pending && !valid_i) || (valid_i && busy_o);
      // a same-cycle start opens a new measurement after the valid closes the old one
      pending <= start_i ? 1'b1 : (valid_i ? 1'b0 : pending);
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            quo   <= {1'b0, cycles_i} + HALF;
            rem   <= '0;
            iter  <= '0;
            state <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem  <= rem_ge ? (rem_sh - DIVISOR) : rem_sh;
          quo  <= {quo[DW-2:0], rem_ge};
          iter <= iter + 1'b1;
          if (iter == LAST_IT)
            state <= ST_OUT;
        end
        ST_OUT: begin
          res_q  <= quo;
          res_go <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cm_valid_o  <= 1'b0;
      cm_o        <= '0;
      avg_valid_o <= 1'b0;
      avg_o       <= '0;
      range_err_o <= 1'b0;
      wr_ptr      <= '0;
      win_cnt     <= '0;
      sum         <= '0;
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else begin
      cm_valid_o  <= 1'b0;
      avg_valid_o <= 1'b0;
      range_err_o <= 1'b0;
      if (res_go && !accept)
        range_err_o <= 1'b1;
      if (res_go && accept) begin
        cm_o       <= res_q[CM_W-1:0];
        cm_valid_o <= 1'b1;
      end
      // flush beats a same-cycle window update; cm_o is unaffected
      if (flush_i) begin
        wr_ptr  <= '0;
        win_cnt <= '0;
        sum     <= '0;
        for (int i = 0; i < N; i++) win[i] <= '0;
      end else if (res_go && accept) begin
        win[wr_ptr] <= res_q[CM_W-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
        win_cnt     <= cnt_new;
        sum         <= sum_new;
        if (cnt_new == N_CNT) begin
          avg_valid_o <= 1'b1;
          avg_o       <= sum_new[SW-1:AVG_LOG2];
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_range_filter.sv
// Directed bench for echo_range_filter: table of samples plus hand-written corner sequences.
module tb_echo_range_filter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        valid_i;
  logic [16:0] cycles_i;
  logic        flush_i;
  logic        cm_valid_o;
  logic [7:0]  cm_o;
  logic        avg_valid_o;
  logic [7:0]  avg_o;
  logic        range_err_o;
  logic        miss_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  echo_range_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .cycles_i    (cycles_i),
    .flush_i     (flush_i),
    .cm_valid_o  (cm_valid_o),
    .cm_o        (cm_o),
    .avg_valid_o (avg_valid_o),
    .avg_o       (avg_o),
    .range_err_o (range_err_o),
    .miss_o      (miss_o),
    .busy_o      (busy_o)
  );

  always #10 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          flush_before;
    bit          exp_cmv;
    int unsigned exp_cm;
    bit          exp_err;
    bit          exp_avgv;
    int unsigned exp_avg;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // valid at edge k; result pulses must first appear after edge k+20
  task automatic run_sample(input int unsigned cyc, output int early);
    cycles_i = cyc[16:0];
    valid_i  = 1'b1;
    step();
    valid_i  = 1'b0;
    early    = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (cm_valid_o || range_err_o || avg_valid_o) early++;
    end
    step();
  endtask

  initial begin
    int early;
    int seen;

    // cyc, flush_before, cmv, cm, err, avgv, avg
    vecs[0]  = '{29000,  0, 1, 10, 0, 0, 0};
    vecs[1]  = '{1449,   0, 1, 0,  0, 0, 0};
    vecs[2]  = '{1450,   0, 1, 1,  0, 0, 0};
    vecs[3]  = '{4349,   0, 1, 1,  0, 1, 3};
    vecs[4]  = '{4350,   0, 1, 2,  0, 1, 1};
    vecs[5]  = '{29000,  1, 1, 10, 0, 0, 1};
    vecs[6]  = '{58000,  0, 1, 20, 0, 0, 1};
    vecs[7]  = '{87000,  0, 1, 30, 0, 0, 1};
    vecs[8]  = '{116000, 0, 1, 40, 0, 1, 25};
    vecs[9]  = '{116000, 0, 1, 40, 0, 1, 32};
    vecs[10] = '{121800, 0, 0, 40, 1, 0, 32};
    vecs[11] = '{0,      0, 1, 0,  0, 1, 27};
    vecs[12] = '{131071, 0, 0, 0,  1, 0, 27};

    rst_n = 1'b0; start_i = 1'b0; valid_i = 1'b0; cycles_i = '0; flush_i = 1'b0;
    step();
    step();
    chk("reset cm_valid", cm_valid_o, 0);
    chk("reset cm", cm_o, 0);
    chk("reset avg_valid", avg_valid_o, 0);
    chk("reset avg", avg_o, 0);
    chk("reset range_err", range_err_o, 0);
    chk("reset miss", miss_o, 0);
    chk("reset busy", busy_o, 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].flush_before) begin
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
      end
      run_sample(vecs[v].cyc, early);
      chk($sformatf("vec%0d early pulse", v), early, 0);
      chk($sformatf("vec%0d cm_valid", v), cm_valid_o, vecs[v].exp_cmv);
      chk($sformatf("vec%0d cm", v), cm_o, vecs[v].exp_cm);
      chk($sformatf("vec%0d range_err", v), range_err_o, vecs[v].exp_err);
      chk($sformatf("vec%0d avg_valid", v), avg_valid_o, vecs[v].exp_avgv);
      chk($sformatf("vec%0d avg", v), avg_o, vecs[v].exp_avg);
      chk($sformatf("vec%0d miss", v), miss_o, 0);
      step();
      chk($sformatf("vec%0d pulse width", v), cm_valid_o | range_err_o | avg_valid_o, 0);
    end

    // Lost echo: second start with no valid in between
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("first start miss", miss_o, 0);
    step(); step(); step();
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("lost echo miss", miss_o, 1);
    step();
    chk("lost echo miss width", miss_o, 0);
    start_i = 1'b1; valid_i = 1'b1; cycles_i = 17'd29000;
    step();
    start_i = 1'b0; valid_i = 1'b0;
    chk("start+valid no miss", miss_o, 0);
    chk("busy after accept", busy_o, 1);
    for (int i = 1; i <= 19; i++) step();
    step();
    chk("lost echo sample cm", cm_o, 10);
    chk("lost echo sample avg", avg_o, 22);

    // valid while busy is dropped
    step();
    cycles_i = 17'd58000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step(); step(); step(); step();
    cycles_i = 17'd29000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("busy drop miss", miss_o, 1);
    for (int i = 0; i < 15; i++) step();
    chk("busy drop result cm_valid", cm_valid_o, 1);
    chk("busy drop result cm", cm_o, 20);
    chk("busy drop avg", avg_o, 17);

    // flush coincident with the result update
    step();
    cycles_i = 17'd87000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 1; i <= 19; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush+out cm_valid", cm_valid_o, 1);
    chk("flush+out cm", cm_o, 30);
    chk("flush+out avg_valid", avg_valid_o, 0);
    chk("flush+out avg hold", avg_o, 17);
    seen = 0;
    for (int s = 0; s < 3; s++) begin
      run_sample(32'd29000, early);
      if (avg_valid_o) seen++;
    end
    run_sample(32'd58000, early);
    chk("post flush avg_valid count", seen, 0);
    chk("4th after flush avg_valid", avg_valid_o, 1);
    chk("4th after flush avg", avg_o, 12);

    // reset in the middle of a division
    step();
    cycles_i = 17'd116000; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid-div reset cm", cm_o, 0);
    chk("mid-div reset avg", avg_o, 0);
    chk("mid-div reset busy", busy_o, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (cm_valid_o || avg_valid_o || range_err_o || miss_o || busy_o) seen++;
    end
    chk("mid-div reset no pulses", seen, 0);
    chk("mid-div reset cm after", cm_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
